// File: rtl/simon_input_checker.sv
// Purpose: Simon game checker; stores a color sequence and verifies player button presses against it.
// Latency: press decision is registered (visible next cycle); round_pass one cycle after the last correct press.
// Backpressure: seq_ready high only in IDLE; appends offered in any other state are ignored.
//
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   seq_valid/color    - generator offers one color (0..3) to append; seq_ready accepts it
//   btn                - one-hot single-cycle player press, bit i = color i
//   restart            - single-cycle pulse clearing the game from FAIL or WIN
//   level              - number of stored colors (0..DEPTH)
//   round_pass         - one-cycle pulse when the whole sequence was reproduced
//   fail, win          - level-high status while in FAIL / WIN
//   expect_color       - color at the current check index while in CHECK, 0 otherwise
module simon_input_checker #(
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       seq_valid,
  input  logic [1:0] seq_color,
  output logic       seq_ready,
  input  logic [3:0] btn,
  input  logic       restart,
  output logic [4:0] level,
  output logic       round_pass,
  output logic       fail,
  output logic       win,
  output logic [1:0] expect_color
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_PASS  = 3'd2;
  localparam logic [2:0] S_FAIL  = 3'd3;
  localparam logic [2:0] S_WIN   = 3'd4;

  logic [2:0]    r_state;
  logic [4:0]    r_level;
  logic [4:0]    r_idx;
  logic [TW-1:0] r_timer;
  logic [1:0]    r_mem [DEPTH];

  logic          w_btn_onehot;
  logic [1:0]    w_btn_color;
  logic [1:0]    w_exp_color;
  logic          w_append;

  // Address slices: level < DEPTH whenever an append is possible and
  // idx < level while checking, so truncation never aliases.
  assign w_exp_color = r_mem[r_idx[AW-1:0]];
  assign w_append    = (r_state == S_IDLE) && seq_valid;

  always_comb begin
    w_btn_onehot = 1'b1;
    w_btn_color  = 2'd0;
    case (btn)
      4'b0001: w_btn_color = 2'd0;
      4'b0010: w_btn_color = 2'd1;
      4'b0100: w_btn_color = 2'd2;
      4'b1000: w_btn_color = 2'd3;
      default: w_btn_onehot = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_level <= 5'd0;
      r_idx   <= 5'd0;
      r_timer <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (seq_valid) begin
            r_level <= r_level + 5'd1;
            r_idx   <= 5'd0;
            r_timer <= '0;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (btn == 4'b0000) begin
            // A press in the final allowed cycle still counts, so the
            // timeout only fires on an idle cycle at the limit.
            if (r_timer == TIMER_MAX) begin
              r_state <= S_FAIL;
            end else begin
              r_timer <= r_timer + TW'(1);
            end
          end else if (w_btn_onehot && (w_btn_color == w_exp_color)) begin
            r_idx   <= r_idx + 5'd1;
            r_timer <= '0;
            if ((r_idx + 5'd1) == r_level) begin
              r_state <= S_PASS;
            end
          end else begin
            r_state <= S_FAIL;
          end
        end
        S_PASS: begin
          r_state <= (r_level == 5'(DEPTH)) ? S_WIN : S_IDLE;
        end
        S_FAIL, S_WIN: begin
          if (restart) begin
            r_state <= S_IDLE;
            r_level <= 5'd0;
            r_idx   <= 5'd0;
            r_timer <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sequence storage is intentionally not cleared by reset or restart;
  // level alone defines which entries are meaningful.
  always_ff @(posedge clk) begin
    if (!rst && w_append) begin
      r_mem[r_level[AW-1:0]] <= seq_color;
    end
  end

  assign seq_ready    = (r_state == S_IDLE);
  assign level        = r_level;
  assign round_pass   = (r_state == S_PASS);
  assign fail         = (r_state == S_FAIL);
  assign win          = (r_state == S_WIN);
  assign expect_color = (r_state == S_CHECK) ? w_exp_color : 2'd0;

endmodule

// File: tb/tb_simon_input_checker.sv
// Purpose: scoreboard bench for simon_input_checker (DEPTH=4, TIMEOUT_CYCLES=8).
// Latency: expected pass/fail/win events carry the exact cycle they must appear in.
// Backpressure: appends are only issued when seq_ready is expected high.
module tb_simon_input_checker;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;
  localparam int EV_PASS = 1;
  localparam int EV_FAIL = 2;
  localparam int EV_WIN  = 3;

  typedef struct {
    int kind;
    int lvl;
    int cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       seq_valid = 1'b0;
  logic [1:0] seq_color = 2'd0;
  logic       seq_ready;
  logic [3:0] btn = 4'd0;
  logic       restart = 1'b0;
  logic [4:0] level;
  logic       round_pass;
  logic       fail;
  logic       win;
  logic [1:0] expect_color;

  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  ev_t  exp_q[$];
  logic [1:0] seq_m[$];
  logic fail_q = 1'b0;
  logic win_q  = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  simon_input_checker #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .seq_valid(seq_valid), .seq_color(seq_color),
    .seq_ready(seq_ready), .btn(btn), .restart(restart), .level(level),
    .round_pass(round_pass), .fail(fail), .win(win), .expect_color(expect_color)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every pass pulse, fail rise or win rise pops one expectation.
  task automatic ev_check(input int kind);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL sb_unexpected: kind=%0d level=%0d cycle=%0d, nothing expected", kind, level, cyc);
    end else begin
      e = exp_q.pop_front();
      if (kind != e.kind || int'(level) != e.lvl || cyc != e.cyc) begin
        n_err++;
        $display("FAIL sb_event: got kind=%0d level=%0d cycle=%0d expected kind=%0d level=%0d cycle=%0d",
                 kind, level, cyc, e.kind, e.lvl, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (round_pass === 1'b1) ev_check(EV_PASS);
    if (fail === 1'b1 && fail_q !== 1'b1) ev_check(EV_FAIL);
    if (win === 1'b1 && win_q !== 1'b1) ev_check(EV_WIN);
    fail_q = fail;
    win_q  = win;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] oh(input logic [1:0] c);
    logic [3:0] one;
    one = 4'b0001;
    return one << c;
  endfunction

  task automatic expect_ev(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.lvl  = seq_m.size();
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic press(input logic [3:0] b, input int kind);
    if (kind != 0) expect_ev(kind, cyc + 1);
    btn = b;
    tick();
    btn = 4'd0;
  endtask

  task automatic append(input logic [1:0] c);
    chk("seq_ready_idle", seq_ready, 1);
    seq_valid = 1'b1;
    seq_color = c;
    seq_m.push_back(c);
    tick();
    seq_valid = 1'b0;
    chk("level_after_append", level, seq_m.size());
  endtask

  task automatic play_all();
    int n;
    n = seq_m.size();
    for (int i = 0; i < n; i++) press(oh(seq_m[i]), (i == n - 1) ? EV_PASS : 0);
    if (n == DEPTH) expect_ev(EV_WIN, cyc + 1);
    tick();
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    seq_m.delete();
    chk("restart_level", level, 0);
    chk("restart_seq_ready", seq_ready, 1);
    chk("restart_fail", fail, 0);
    chk("restart_win", win, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int lowcnt;

    // Reset values
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_level", level, 0);
    chk("rst_seq_ready", seq_ready, 1);
    chk("rst_round_pass", round_pass, 0);
    chk("rst_fail", fail, 0);
    chk("rst_win", win, 0);
    chk("rst_expect_color", expect_color, 0);

    // Single color round: pass pulse, then ready again
    append(2'd2);
    chk("check_seq_ready", seq_ready, 0);
    chk("check_expect_color", expect_color, 2);
    press(4'b0100, EV_PASS);
    chk("pass_round_pass", round_pass, 1);
    chk("pass_seq_ready", seq_ready, 0);
    tick();
    chk("after_pass_round_pass", round_pass, 0);
    chk("after_pass_seq_ready", seq_ready, 1);
    chk("after_pass_level", level, 1);

    // Restart ignored in CHECK, then a multi-bit press fails
    append(2'd1);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("restart_in_check_level", level, 2);
    chk("restart_in_check_expect", expect_color, 2);
    press(4'b0011, EV_FAIL);
    chk("multibit_fail", fail, 1);
    do_restart();

    // Sequence 1,3,0 with a wrong final press; FAIL is sticky
    append(2'd1);
    play_all();
    append(2'd3);
    play_all();
    append(2'd0);
    press(4'b0010, 0);
    chk("idx1_expect_color", expect_color, 3);
    press(4'b1000, 0);
    chk("idx2_expect_color", expect_color, 0);
    press(4'b0100, EV_FAIL);
    chk("wrong_color_fail", fail, 1);
    lowcnt = 0;
    for (int i = 0; i < 100; i++) begin
      btn       = oh(i[1:0]);
      seq_valid = i[0];
      tick();
      if (fail !== 1'b1) lowcnt++;
    end
    btn       = 4'd0;
    seq_valid = 1'b0;
    chk("fail_sticky_low_cycles", lowcnt, 0);
    chk("fail_sticky_level", level, 3);
    chk("fail_seq_ready", seq_ready, 0);
    do_restart();

    // Timeout: no press fails 8 cycles after entering CHECK
    a = cyc;
    seq_m.push_back(2'd1);
    expect_ev(EV_FAIL, a + 9);
    seq_m.delete();
    append(2'd1);
    repeat (7) tick();
    chk("timeout_not_yet", fail, 0);
    tick();
    chk("timeout_fail", fail, 1);
    do_restart();

    // Correct press in the last allowed cycle avoids the timeout
    append(2'd2);
    repeat (7) tick();
    press(4'b0100, EV_PASS);
    chk("late_press_no_fail", fail, 0);
    tick();

    // Fill to DEPTH: fourth pass leads to sticky WIN
    append(2'd0);
    play_all();
    append(2'd3);
    play_all();
    append(2'd1);
    play_all();
    chk("win_level", win, 1);
    for (int i = 0; i < 5; i++) begin
      seq_valid = 1'b1;
      seq_color = i[1:0];
      btn       = oh(i[1:0]);
      tick();
    end
    seq_valid = 1'b0;
    btn       = 4'd0;
    chk("win_hold_level", level, 4);
    chk("win_seq_ready", seq_ready, 0);
    chk("win_hold", win, 1);
    do_restart();

    // Reset in the middle of CHECK with idx=2
    append(2'd2);
    play_all();
    append(2'd1);
    play_all();
    append(2'd3);
    press(4'b0100, 0);
    press(4'b0010, 0);
    chk("midcheck_expect_color", expect_color, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seq_m.delete();
    chk("midrst_level", level, 0);
    chk("midrst_seq_ready", seq_ready, 1);
    chk("midrst_round_pass", round_pass, 0);
    chk("midrst_fail", fail, 0);
    chk("midrst_win", win, 0);
    chk("midrst_expect_color", expect_color, 0);
    btn = 4'b0001;
    tick();
    btn = 4'b1000;
    tick();
    btn = 4'd0;
    tick();
    chk("stray_btn_level", level, 0);
    chk("stray_btn_seq_ready", seq_ready, 1);
    chk("stray_btn_fail", fail, 0);
    append(2'd0);
    play_all();
    chk("post_rst_round_ready", seq_ready, 1);

    repeat (3) tick();
    chk("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
